// File: rtl/gcm_out_packer.sv
// ---------------------------------------------------------------------------
// gcm_out_packer
//
// Purpose:
//   Sits downstream of the gcm core. The core cannot be stalled on its
//   output, so whole 128-bit result blocks are captured into a small block
//   FIFO. Each block is then serialised into AXI-Stream words, most
//   significant word first. The final word of each message (the tag block)
//   carries tlast.
//
//   Knowing that a word is the last of a message requires knowing whether
//   another block will follow it. For this reason, the final word of the
//   only buffered block is held back until one of two things happens:
//     - another block arrives (the word is not the last), or
//     - gcm_done arrives (the word is the last).
//
// Optional build feature:
//   GCM_OUT_BSWAP_EN - when defined, every emitted word is byte-reversed.
//   This matches the little-endian DMA memory layout. Word order and timing
//   are unchanged.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-low reset (0 = reset)
//   in_blk            block from gcm_out_blk
//   in_store          one-cycle write strobe (gcm_out_store_blk)
//   in_done           one-cycle end-of-message pulse (gcm_done)
//   m_axis_tdata      output word
//   m_axis_tvalid     output word valid
//   m_axis_tready     downstream ready
//   m_axis_tlast      final word of the message
//   fifo_almost_full  FIFO holds FIFO_DEPTH-1 or more blocks (advisory stall)
//   overflow          sticky; set when a block was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module gcm_out_packer #(
  parameter int BLK_BITS   = 128,
  parameter int WORD_BITS  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BLK_BITS-1:0]  in_blk,
  input  logic                 in_store,
  input  logic                 in_done,
  output logic [WORD_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 fifo_almost_full,
  output logic                 overflow
);

  localparam int WORDS = BLK_BITS / WORD_BITS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [BLK_BITS-1:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             done_seen_q, done_seen_d;
  logic             overflow_q, overflow_d;
  logic             almost_full_q, almost_full_d;

  logic                 last_word;
  logic                 hold;
  logic                 tvalid;
  logic                 tlast;
  logic                 handshake;
  logic                 pop;
  logic                 full;
  logic                 store_accept;
  logic [BLK_BITS-1:0]  head_blk;
  logic [WORD_BITS-1:0] raw_word;
  logic [WORD_BITS-1:0] out_word;

  // Block storage. The contents need no reset, because the occupancy
  // count decides what is valid.
  always_ff @(posedge clk) begin
    if (store_accept) begin
      fifo_mem[wr_ptr_q] <= in_blk;
    end
  end

  // Handshake, hold and FIFO bookkeeping.
  always_comb begin
    last_word = (word_idx_q == LAST_IDX);
    // The only remaining block may be the tag block, so its final word
    // waits until we know whether a further block or gcm_done comes first.
    hold      = (count_q == ONE_CNT) && last_word && !done_seen_q;
    tvalid    = (count_q != '0) && !hold;
    tlast     = tvalid && last_word && (count_q == ONE_CNT) && done_seen_q;
    handshake = tvalid && m_axis_tready;
    pop       = handshake && last_word;
    full      = (count_q == FULL_CNT);
    // A write into a full FIFO succeeds if the head block leaves in the
    // same cycle.
    store_accept = in_store && (!full || pop);

    wr_ptr_d   = store_accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    word_idx_d = word_idx_q;
    if (handshake) begin
      word_idx_d = last_word ? '0 : word_idx_q + IDX_W'(1);
    end
    count_d = count_q + CNT_W'(store_accept) - CNT_W'(pop);

    // gcm_done marks the newest buffered block, including a block written
    // in the same cycle. It is ignored if the FIFO is empty afterwards.
    done_seen_d = done_seen_q;
    if (handshake && tlast) begin
      done_seen_d = 1'b0;
    end
    if (in_done && (count_d != '0)) begin
      done_seen_d = 1'b1;
    end

    overflow_d    = overflow_q | (in_store && full && !pop);
    almost_full_d = (count_d >= AF_CNT);
  end

  // Word selection and output gating. tdata reads as zero whenever no
  // word is being offered.
  always_comb begin
    head_blk = fifo_mem[rd_ptr_q];
    raw_word = head_blk[BLK_BITS - 1 - int'(word_idx_q) * WORD_BITS -: WORD_BITS];
`ifdef GCM_OUT_BSWAP_EN
    out_word = '0;
    for (int b = 0; b < WORD_BITS / 8; b++) begin
      out_word[8*b +: 8] = raw_word[WORD_BITS - 8 - 8*b +: 8];
    end
`else
    out_word = raw_word;
`endif
    m_axis_tvalid    = tvalid;
    m_axis_tlast     = tlast;
    m_axis_tdata     = tvalid ? out_word : '0;
    overflow         = overflow_q;
    fifo_almost_full = almost_full_q;
  end

  // State registers. Because of the asynchronous clear, tvalid drops as
  // soon as reset is applied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      word_idx_q    <= '0;
      done_seen_q   <= 1'b0;
      overflow_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      word_idx_q    <= word_idx_d;
      done_seen_q   <= done_seen_d;
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
    end
  end

endmodule
